square_wave_analyzer: RTL
=========================

// Module: square_wave_analyzer
// PURPOSE
//  Receive-side counterpart of the 8-bit square-wave sample generator.
//  - Takes an 8-bit sample stream (ADC capture or generator loopback) and slices it with hysteresis.
//  - Measures each full cycle: period, high time, and min/max amplitude.
//  - Publishes one result per complete period; flags loss of signal.
// PARAMETERS
//  CNT_W  16   width of the high/low sample counters (saturating)
//  HI_TH  192  level goes high when sample >= HI_TH
//  LO_TH  64   level goes low when sample <= LO_TH; HI_TH > LO_TH (elaboration check)
// PORTS
//  clk           in   1        system clock, rising edge
//  rst           in   1        asynchronous, active-low reset
//  sample        in   8        unsigned input sample
//  sample_valid  in   1        sample qualifier; state advances only on valid cycles
//  period        out  CNT_W+1  samples in last full period (high_time + low count)
//  high_time     out  CNT_W    samples at high level in last period
//  peak_max      out  8        max sample over last period
//  peak_min      out  8        min sample over last period
//  meas_valid    out  1        1-cycle pulse: period/high_time/peaks updated
//  timeout       out  1        1-cycle pulse: counter saturated, measurement abandoned
//  locked        out  1        1 while in MEAS_HIGH/MEAS_LOW
// BEHAVIOUR
//  Reset (rst=0, async): every output 0; level=0; counters 0; run_max=0x00; run_min=0xFF; state ACQUIRE.
//  Level slicer (valid cycles only):
//  - level 0->1 when sample>=HI_TH; 1->0 when sample<=LO_TH; otherwise hold.
//  - rise/fall = combinational change of level on the current valid sample.
//  FSM on valid cycles; sample_valid=0 => nothing changes, pulses stay 0.
//  ACQUIRE:
//  - on rise -> MEAS_HIGH; hcnt=1; lcnt=0; run_max=run_min=sample.
//  MEAS_HIGH:
//  - on fall -> MEAS_LOW, lcnt=1;
//  - else hcnt++.
//  - Track run_max/run_min every valid sample.
//  MEAS_LOW:
//  - on rise: next cycle period=hcnt+lcnt, high_time=hcnt, peaks=run_max/run_min, meas_valid=1;
//    then -> MEAS_HIGH with hcnt=1, lcnt=0, run_max=run_min=sample.
//  - else lcnt++.
//  - The crossing sample counts as the first sample of the new level and seeds the new peaks.
//  Latency: meas_valid registered 1 clk after the valid sample that caused the rise.
//  Saturation: a counter already at 2^CNT_W-1 that would increment instead:
//  - pulse timeout next clk; -> ACQUIRE; counters cleared.
//  - Outputs keep last results. level keeps tracking.
//  Result regs hold until the next meas_valid or reset.
//  Widths: period is CNT_W+1 bits, so no overflow. No divide; duty = high_time/period is computed downstream.
// STRUCTURE
//  Shared package sw_meas_pkg holds:
//  - state encoding ACQUIRE=2'd0, MEAS_HIGH=2'd1, MEAS_LOW=2'd2;
//  - default thresholds SW_HI_TH=8'd192, SW_LO_TH=8'd64.
//  Sub-module sw_level_slicer: hysteresis register + rise/fall strobes.
//  Top holds the FSM, counters, peak trackers and result registers.
// TESTING
//  T1 CNT_W=16, full valid: 10x 0x00, then repeat {128x 0xFF, 128x 0x00}
//     -> first meas_valid after 2nd rise; period=256, high_time=128, peak_max=0xFF, peak_min=0x00.
//  T2 same wave, sample_valid high every other clk -> identical results; meas_valid at half rate.
//  T3 high phase 50x 0xFF, 10x 0x80, 68x 0xFF, then 128x 0x10
//     -> no false edge; high_time=128, period=256, peak_min=0x10.
//  T4 CNT_W=8: rise, then constant 0xFF
//     -> timeout pulse on the 256th high sample, locked=0, next rise relocks.
//  T5 rst low mid-MEAS_LOW, then release
//     -> all outputs 0 immediately; first meas_valid only after 2 new rises.
//  T6 duty 25%: {64x 0xC0, 192x 0x40} -> period=256, high_time=64, peak_max=0xC0, peak_min=0x40.

Source files
------------

// File: rtl/sw_meas_pkg.sv
// Shared types and default thresholds for the square-wave measurement path.
package sw_meas_pkg;

  typedef enum logic [1:0] {
    ACQUIRE   = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } sw_state_e;

  localparam logic [7:0] SW_HI_TH = 8'd192;
  localparam logic [7:0] SW_LO_TH = 8'd64;

endpackage

// File: rtl/sw_level_slicer.sv
// Hysteresis slicer: holds the current logic level and strobes rise/fall
// combinationally on the valid sample that flips it.
module sw_level_slicer
  import sw_meas_pkg::*;
#(
  parameter logic [7:0] HI_TH = SW_HI_TH,
  parameter logic [7:0] LO_TH = SW_LO_TH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic       rise,
  output logic       fall
);

  logic level_q, level_d;

  always_comb begin
    rise    = sample_valid && !level_q && (sample >= HI_TH);
    fall    = sample_valid &&  level_q && (sample <= LO_TH);
    level_d = level_q;
    if (rise) begin
      level_d = 1'b1;
    end else if (fall) begin
      level_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/square_wave_analyzer.sv
// Square-wave analyzer: measures period, high time and peak levels per full cycle,
// publishing one result one clock after the closing rising edge.
module square_wave_analyzer
  import sw_meas_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter logic [7:0]  HI_TH = SW_HI_TH,
  parameter logic [7:0]  LO_TH = SW_LO_TH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sample,
  input  logic             sample_valid,
  output logic [CNT_W:0]   period,
  output logic [CNT_W-1:0] high_time,
  output logic [7:0]       peak_max,
  output logic [7:0]       peak_min,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (HI_TH <= LO_TH) begin : g_bad_thresholds
    $error("square_wave_analyzer: HI_TH must be greater than LO_TH");
  end

  sw_state_e        state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [7:0]       run_max_q, run_max_d, run_min_q, run_min_d;
  logic [CNT_W:0]   period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [7:0]       pmax_q, pmax_d, pmin_q, pmin_d;
  logic             meas_q, meas_d, tmo_q, tmo_d;
  logic             rise, fall;

  sw_level_slicer #(
    .HI_TH (HI_TH),
    .LO_TH (LO_TH)
  ) u_slicer (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .rise         (rise),
    .fall         (fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACQUIRE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sample_valid) begin
      case (state_q)
        ACQUIRE:   if (rise) state_d = MEAS_HIGH;
        MEAS_HIGH: begin
          if (fall)                  state_d = MEAS_LOW;
          else if (hcnt_q == CNT_MAX) state_d = ACQUIRE;
        end
        MEAS_LOW: begin
          if (rise)                  state_d = MEAS_HIGH;
          else if (lcnt_q == CNT_MAX) state_d = ACQUIRE;
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  // Datapath: counters, running peaks, result capture and the two pulses.
  always_comb begin
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    period_d  = period_q;
    high_d    = high_q;
    pmax_d    = pmax_q;
    pmin_d    = pmin_q;
    meas_d    = 1'b0;
    tmo_d     = 1'b0;
    if (sample_valid) begin
      if (sample > run_max_q) run_max_d = sample;
      if (sample < run_min_q) run_min_d = sample;
      case (state_q)
        ACQUIRE: begin
          if (rise) begin
            hcnt_d    = CNT_ONE;
            lcnt_d    = '0;
            run_max_d = sample;
            run_min_d = sample;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            lcnt_d = CNT_ONE;
          end else if (hcnt_q == CNT_MAX) begin
            tmo_d     = 1'b1;
            hcnt_d    = '0;
            lcnt_d    = '0;
            run_max_d = 8'h00;
            run_min_d = 8'hFF;
          end else begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            // The rising sample closes this period and opens the next one.
            period_d  = {1'b0, hcnt_q} + {1'b0, lcnt_q};
            high_d    = hcnt_q;
            pmax_d    = run_max_q;
            pmin_d    = run_min_q;
            meas_d    = 1'b1;
            hcnt_d    = CNT_ONE;
            lcnt_d    = '0;
            run_max_d = sample;
            run_min_d = sample;
          end else if (lcnt_q == CNT_MAX) begin
            tmo_d     = 1'b1;
            hcnt_d    = '0;
            lcnt_d    = '0;
            run_max_d = 8'h00;
            run_min_d = 8'hFF;
          end else begin
            lcnt_d = lcnt_q + CNT_ONE;
          end
        end
        default: begin
          hcnt_d = '0;
          lcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      run_max_q <= 8'h00;
      run_min_q <= 8'hFF;
      period_q  <= '0;
      high_q    <= '0;
      pmax_q    <= 8'h00;
      pmin_q    <= 8'h00;
      meas_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      period_q  <= period_d;
      high_q    <= high_d;
      pmax_q    <= pmax_d;
      pmin_q    <= pmin_d;
      meas_q    <= meas_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    locked     = (state_q == MEAS_HIGH) || (state_q == MEAS_LOW);
    period     = period_q;
    high_time  = high_q;
    peak_max   = pmax_q;
    peak_min   = pmin_q;
    meas_valid = meas_q;
    timeout    = tmo_q;
  end

endmodule
